display_scan: RTL and testbench

Time-multiplexed scan controller for the clock's common-anode 7-segment display. Takes the packed BCD time digits from the timekeeping counters and presents one digit per scan slot on `bcd`, which feeds the BCD-to-segment decoder. Drives the active-low digit enables and decimal point. Adds per-digit blink for time-setting mode, leading-zero blanking and an inter-digit dead time against ghosting.

---
 rtl/display_scan_pkg.sv | 24 ++
 rtl/clk_divider.sv | 32 +++
 rtl/display_scan.sv | 138 +++++++++++++
 tb/tb_display_scan.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// display_scan_pkg -- shared constants for the 7-segment scan controller.
//
// Holds the digit code width and the default scan geometry derived from the
// board clock.  Imported by display_scan and clk_divider.
package display_scan_pkg;

   // Width of one BCD digit code.
   localparam int DIGIT_W = 4;

   // Board clock and the defaults derived from it.
   localparam int CLK_HZ          = 50_000_000;
   localparam int DEF_DIGITS      = 6;
   // 1 kHz slot rate -> ~167 Hz full-frame refresh with six digits.
   localparam int DEF_SCAN_DIV    = CLK_HZ / 1000;
   localparam int DEF_DEAD        = 2;
   // Half a second per blink phase -> 1 Hz blink.
   localparam int DEF_BLINK_DIV   = CLK_HZ / 2;

   // Counter width able to hold 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_divider.sv
// clk_divider -- modulo-N free-running counter with terminal-count flag.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (count returns to 0)
//   count  out  current count, 0..N-1
//   tc     out  high during the cycle where count = N-1 (the wrap cycle)
import display_scan_pkg::*;

module clk_divider #(
   parameter int N = 4,
   parameter int W = cnt_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [W-1:0] count,
   output logic         tc
);

   assign tc = (count == W'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tc) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/display_scan.sv
// display_scan -- time-multiplexed scan controller for a common-anode
// 7-segment display.
//
// One digit is shown per scan slot.  Each slot starts with DEAD cycles of all
// anodes off so the previous digit's segments can discharge (anti-ghosting).
// The digit word is captured into a shadow register once per frame, so a
// frame always shows one coherent time value.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   digits       in   packed BCD, digit i at [4i+3:4i], digit 0 rightmost
//   blink_mask   in   1 = digit i blinks (sampled live)
//   dp_mask      in   1 = decimal point lit while digit i is shown
//   blank_lz     in   1 = blank leading zeros
//   bcd          out  current digit code to the segment decoder (registered)
//   an           out  active-low digit enables, one-hot-low or all high
//   dp           out  active-low decimal point
//   frame_start  out  one-cycle pulse when slot 0 begins
import display_scan_pkg::*;

module display_scan #(
   parameter int DIGITS    = DEF_DIGITS,
   parameter int SCAN_DIV  = DEF_SCAN_DIV,
   parameter int DEAD      = DEF_DEAD,
   parameter int BLINK_DIV = DEF_BLINK_DIV
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DIGIT_W*DIGITS-1:0] digits,
   input  logic [DIGITS-1:0]         blink_mask,
   input  logic [DIGITS-1:0]         dp_mask,
   input  logic                      blank_lz,
   output logic [DIGIT_W-1:0]        bcd,
   output logic [DIGITS-1:0]         an,
   output logic                      dp,
   output logic                      frame_start
);

   localparam int SEL_W = cnt_width(DIGITS);
   localparam int PW    = cnt_width(SCAN_DIV);
   localparam int BW    = cnt_width(BLINK_DIV);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

   logic [PW-1:0]                 pcnt;
   logic                          tick;
   logic [BW-1:0]                 blink_cnt_unused;
   logic                          blink_wrap;
   logic                          bphase;
   logic [SEL_W-1:0]              sel;
   logic [DIGIT_W*DIGITS-1:0]     shadow;

   logic [DIGITS-1:0]             lz_blank;
   logic [DIGITS-1:0]             blank;
   logic [DIGIT_W-1:0]            cur_digit;
   logic                          cur_en;
   logic [DIGITS-1:0]             an_next;
   logic                          dp_next;

   // Slot prescaler: the wrap cycle advances the slot.
   clk_divider #(.N(SCAN_DIV), .W(PW)) u_scan_div (
      .clk   (clk),
      .rst_n (rst_n),
      .count (pcnt),
      .tc    (tick)
   );

   // Blink half-period divider, free-running and independent of the scan.
   clk_divider #(.N(BLINK_DIV), .W(BW)) u_blink_div (
      .clk   (clk),
      .rst_n (rst_n),
      .count (blink_cnt_unused),
      .tc    (blink_wrap)
   );

   // Slot counter and once-per-frame shadow capture.  Reset parks sel on the
   // last slot so the first tick enters slot 0 and loads the shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel    <= SEL_LAST;
         shadow <= '0;
      end else if (tick) begin
         if (sel == SEL_LAST) begin
            sel    <= '0;
            shadow <= digits;
         end else begin
            sel    <= sel + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bphase <= 1'b0;
      end else if (blink_wrap) begin
         bphase <= ~bphase;
      end
   end

   // Leading-zero blanking: walk down from the most significant digit while
   // every digit seen so far is zero.  Digit 0 is never blanked.
   always_comb begin
      logic still_zero;
      lz_blank   = '0;
      still_zero = blank_lz;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         still_zero  = still_zero && (shadow[i*DIGIT_W +: DIGIT_W] == '0);
         lz_blank[i] = still_zero;
      end
   end

   always_comb begin
      blank     = lz_blank | (bphase ? blink_mask : '0);
      cur_digit = shadow[{sel, 2'b00} +: DIGIT_W];
      cur_en    = (pcnt >= PW'(DEAD)) && !blank[sel];
      an_next   = '1;
      an_next[sel] = ~cur_en;
      dp_next   = cur_en ? ~dp_mask[sel] : 1'b1;
   end

   // Output stage: everything leaves through a flop, one stage behind the
   // scan state.  frame_start marks the first output cycle of slot 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd         <= '0;
         an          <= '1;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         bcd         <= cur_digit;
         an          <= an_next;
         dp          <= dp_next;
         frame_start <= (sel == '0) && (pcnt == '0);
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan -- directed self-checking bench for display_scan.
//
// Geometry: DIGITS=6, SCAN_DIV=4, DEAD=1, BLINK_DIV=24.  One frame is 24
// cycles.  Outputs are sampled on the falling edge; inputs are driven there.
// Within a frame, slot s occupies sample offsets 4s (dead, all anodes off)
// and 4s+1..4s+3 (digit enabled unless blanked).
module tb_display_scan;

   localparam int DIGITS    = 6;
   localparam int SCAN_DIV  = 4;
   localparam int DEAD      = 1;
   localparam int BLINK_DIV = 24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] digits = '0;
   logic [5:0]  blink_mask = '0;
   logic [5:0]  dp_mask = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  bcd;
   logic [5:0]  an;
   logic        dp;
   logic        frame_start;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   display_scan #(
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV),
      .DEAD      (DEAD),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digits      (digits),
      .blink_mask  (blink_mask),
      .dp_mask     (dp_mask),
      .blank_lz    (blank_lz),
      .bcd         (bcd),
      .an          (an),
      .dp          (dp),
      .frame_start (frame_start)
   );

   // ---------------- checker ----------------
   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_an"},  32'(an),          32'h3f);
      check_val({tag, "_dp"},  32'(dp),          32'h1);
      check_val({tag, "_bcd"}, 32'(bcd),         32'h0);
      check_val({tag, "_fs"},  32'(frame_start), 32'h0);
   endtask

   // Release reset on a falling edge and wait for the first frame_start.
   // The first tick is the 4th rising edge after release (sel -> 0, shadow
   // loaded); the registered outputs show slot 0 one edge later, so
   // frame_start is first seen after the 5th rising edge.
   task automatic release_and_sync(input string tag);
      int lat;
      @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!frame_start && lat < 40);
      check_val({tag, "_fs_latency"}, 32'(lat), 32'd5);
   endtask

   // Check one whole frame starting at the dead sample of slot 0; returns at
   // the dead sample of slot 0 of the following frame.  Optionally changes
   // the digits input mid-frame (at slot 2) to prove the shadow holds.
   task automatic check_frame(input string tag, input logic [23:0] exp_d,
                              input logic [5:0] lit, input logic [5:0] dpm,
                              input bit mid, input logic [23:0] mid_val);
      logic [5:0] exp_an;
      logic [3:0] exp_bcd;
      logic       exp_dp;
      for (int s = 0; s < DIGITS; s++) begin
         exp_bcd = exp_d[4*s +: 4];
         check_val($sformatf("%s_s%0d_dead_fs", tag, s), 32'(frame_start),
                   32'(s == 0));
         check_val($sformatf("%s_s%0d_dead_an", tag, s), 32'(an), 32'h3f);
         check_val($sformatf("%s_s%0d_dead_dp", tag, s), 32'(dp), 32'h1);
         check_val($sformatf("%s_s%0d_dead_bcd", tag, s), 32'(bcd),
                   32'(exp_bcd));
         if (mid && s == 2) digits = mid_val;
         exp_an = lit[s] ? ~(6'b000001 << s) : 6'h3f;
         exp_dp = (lit[s] && dpm[s]) ? 1'b0 : 1'b1;
         for (int k = 1; k < SCAN_DIV; k++) begin
            @(negedge clk);
            check_val($sformatf("%s_s%0d_c%0d_an", tag, s, k), 32'(an),
                      32'(exp_an));
            check_val($sformatf("%s_s%0d_c%0d_bcd", tag, s, k), 32'(bcd),
                      32'(exp_bcd));
            check_val($sformatf("%s_s%0d_c%0d_dp", tag, s, k), 32'(dp),
                      32'(exp_dp));
         end
         @(negedge clk);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      digits = 24'h235907;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");

      release_and_sync("rst");

      // Shadow latch: digits go to zero during frame 0, frame 0 still shows
      // 7,0,9,5,3,2 and frame 1 shows zeros.
      check_frame("map_f0", 24'h235907, 6'h3f, 6'h00, 1'b1, 24'h000000);
      check_frame("map_f1", 24'h000000, 6'h3f, 6'h00, 1'b1, 24'h000450);

      // Leading-zero blanking with decimal points on digits 2 and 4.  Digit 4
      // is blanked, so its dp must stay dark too.
      blank_lz = 1'b1;
      dp_mask  = 6'b010100;
      check_frame("lz_450", 24'h000450, 6'b000111, 6'b010100, 1'b1, 24'h0);
      check_frame("lz_zero", 24'h000000, 6'b000001, 6'b010100, 1'b0, 24'h0);

      // Mid-scan asynchronous reset during slot 3.  blank_lz is cleared so
      // slot 3 is visibly lit just before reset hits.
      blank_lz = 1'b0;
      dp_mask  = 6'b000000;
      repeat (13) @(negedge clk);
      check_val("pre_async_an", 32'(an), 32'(6'b110111));
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async");

      // Blink on digits 0 and 1.  Blink divider restarts with the scan, so
      // blink phase 1 covers slots 0/1 of every odd frame after release.
      digits     = 24'h123456;
      blink_mask = 6'b000011;
      repeat (2) @(negedge clk);
      release_and_sync("async");
      check_frame("blink_f0", 24'h123456, 6'b111111, 6'h00, 1'b0, 24'h0);
      check_frame("blink_f1", 24'h123456, 6'b111100, 6'h00, 1'b0, 24'h0);
      check_frame("blink_f2", 24'h123456, 6'b111111, 6'h00, 1'b0, 24'h0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
